alu_issue_stage: RTL

- Multicycle operand/issue stage directly upstream of ALU16b; also captures ALU16b result into the ALUOut register.
- Latches register operands, selects the B source, decodes the 3-bit ALU Op, drives ALUScrA/ALUScrB/Op from registers, and samples O one cycle later.
- Valid/ready handshake on both sides, so decode and writeback can stall it.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/alu_issue_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: op encodings, instruction
// class codes, FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_DATA_W = 16;

  // ALU16b operation encodings; 001, 011 and 110 are unused by the ALU.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Instruction class codes presented by decode.
  localparam logic [1:0] CLS_MEM = 2'b00;
  localparam logic [1:0] CLS_BR  = 2'b01;
  localparam logic [1:0] CLS_R   = 2'b10;
  localparam logic [1:0] CLS_I   = 2'b11;

  // Issue FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // True for the five op codes ALU16b implements.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational class/funct decode: ALU op, B-operand source, immediate
// extension mode and illegal-funct flag. Shared with the control unit.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_class_i,
  input  logic [2:0] funct_i,
  output logic [2:0] op_o,
  output logic       b_imm_o,
  output logic       sext_o,
  output logic       illegal_o
);

  logic [2:0] funct_op;
  logic       funct_bad;

  // Illegal funct codes fall back to ADD.
  always_comb begin
    funct_bad = !op_is_legal(funct_i);
    funct_op  = funct_bad ? OP_ADD : funct_i;
  end

  // Class decode; immediates are zero-extended only for the logical ops.
  always_comb begin
    op_o      = OP_ADD;
    b_imm_o   = 1'b0;
    sext_o    = 1'b1;
    illegal_o = 1'b0;
    case (alu_class_i)
      CLS_MEM: begin
        op_o    = OP_ADD;
        b_imm_o = 1'b1;
      end
      CLS_BR: begin
        op_o    = OP_SUB;
        b_imm_o = 1'b0;
      end
      CLS_R: begin
        op_o      = funct_op;
        b_imm_o   = 1'b0;
        illegal_o = funct_bad;
      end
      CLS_I: begin
        op_o      = funct_op;
        b_imm_o   = 1'b1;
        sext_o    = !((funct_op == OP_AND) || (funct_op == OP_OR));
        illegal_o = funct_bad;
      end
      default: begin
        op_o = OP_ADD;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Multicycle operand/issue stage in front of ALU16b. Registers A, B and Op,
// captures the ALU result one cycle later, and handshakes on both sides.
// Optional: define ALU_ILLEGAL_TRAP_EN to force a zero result and raise err
// for illegal funct codes; otherwise they silently execute as ADD.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int IMM_W  = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_class,
  input  logic [2:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] ALUScrA,
  output logic [DATA_W-1:0] ALUScrB,
  output logic [2:0]        Op,
  input  logic [DATA_W-1:0] O,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic              err
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] alu_out_q;
  logic              zero_q;
  logic              out_valid_q;

  logic [2:0]        dec_op;
  logic              dec_b_imm;
  logic              dec_sext;
  logic              dec_illegal;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] b_sel;
  logic              accept;

  alu_op_decode u_dec (
    .alu_class_i (alu_class),
    .funct_i     (funct),
    .op_o        (dec_op),
    .b_imm_o     (dec_b_imm),
    .sext_o      (dec_sext),
    .illegal_o   (dec_illegal)
  );

  // B operand source selection with immediate extension.
  always_comb begin
    imm_ext = dec_sext ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                       : {{(DATA_W-IMM_W){1'b0}}, imm};
    b_sel   = dec_b_imm ? imm_ext : rt_val;
  end

  // Ready is combinational on state; in DONE it passes out_ready through.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_EXEC: in_ready = 1'b0;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
  end

  // Next-state logic for IDLE -> EXEC -> DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = in_valid ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Operand registers load only on accept so the ALU inputs stay steady.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_AND;
    end else if (accept) begin
      a_q  <= rs_val;
      b_q  <= b_sel;
      op_q <= dec_op;
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic err_q;

  // Remember whether the op in flight was an illegal funct.
  always_ff @(posedge CLK) begin
    if (Reset)       illegal_q <= 1'b0;
    else if (accept) illegal_q <= dec_illegal;
  end

  // Result capture; trapped ops produce a zero result with err raised.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          out_valid_q <= 1'b1;
          if (illegal_q) begin
            alu_out_q <= '0;
            zero_q    <= 1'b1;
            err_q     <= 1'b1;
          end else begin
            alu_out_q <= O;
            zero_q    <= (O == '0);
            err_q     <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;

  // Result capture from ALU16b; held through DONE until consumed.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          out_valid_q <= 1'b1;
          alu_out_q   <= O;
          zero_q      <= (O == '0);
        end
        ST_DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign err = 1'b0;
`endif

  assign ALUScrA   = a_q;
  assign ALUScrB   = b_q;
  assign Op        = op_q;
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule
